ip_id_embedder: RTL and testbench

Transmit-side counterpart of the IPv4 ID extraction and windowing path: a one-stage in-line rewriter on the Avalon-ST packet stream. For each qualifying IPv4 packet it replaces the 16-bit Identification field with the next covert message word and patches the header checksum incrementally, so the packet stays valid. It sits between the packet source and the MAC/FIFO, on the same `avln_st` stream type and word layout (W = 32, ethertype in `data[15:0]` of word 3 + VLAN tags) as the receive path.

---
 rtl/ip_id_embedder.sv | 161 ++++++++++++++++
 tb/tb_ip_id_embedder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ip_id_embedder.sv
// In-line IPv4 Identification rewriter: swaps the ID for the next covert word and patches the
// header checksum incrementally, with one cycle of latency on the packet stream.
module ip_id_embedder #(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MAX_VLAN_TAGS = 2
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             in_valid_i,
   input  logic             in_sop_i,
   input  logic             in_eop_i,
   input  logic [31:0]      in_data_i,
   input  logic             enable_i,
   input  logic [15:0]      msg_data_i,
   input  logic             msg_valid_i,
   output logic             msg_pop_o,
   output logic             out_valid_o,
   output logic             out_sop_o,
   output logic             out_eop_o,
   output logic [31:0]      out_data_o,
   output logic [CNT_W-1:0] embed_count_o,
   output logic             short_err_o
);

   typedef enum logic [2:0] {StIdle, StEth, StIpHdr0, StIpId, StIpCsum, StPass} state_e;

   localparam logic [2:0] TMax = 3'(3 + MAX_VLAN_TAGS);

   state_e           state_q, state_d;
   logic [2:0]       k_q, k_d, t_q, t_d, k_inc;
   logic             en_pkt_q, en_pkt_d, rewrite_q, rewrite_d;
   logic [15:0]      m_q, m_d, mn_q, mn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             pop;
   logic [31:0]      odata;
   logic             out_valid_q, out_sop_q, out_eop_q;
   logic [31:0]      out_data_q;

   // RFC 1624 eqn 3: HC' = ~(~HC + ~m + m') with end-around carry
   logic [16:0] s1, s2;
   logic [15:0] s1f, s2f, hc_new;
   always_comb begin
      s1     = {1'b0, ~in_data_i[15:0]} + {1'b0, ~m_q};
      s1f    = s1[15:0] + {15'd0, s1[16]};
      s2     = {1'b0, s1f} + {1'b0, mn_q};
      s2f    = s2[15:0] + {15'd0, s2[16]};
      hc_new = ~s2f;
   end

   assign k_inc = k_q + 3'd1;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      t_d       = t_q;
      en_pkt_d  = en_pkt_q;
      rewrite_d = rewrite_q;
      m_d       = m_q;
      mn_d      = mn_q;
      cnt_d     = cnt_q;
      short_d   = short_q;
      pop       = 1'b0;
      odata     = in_data_i;
      if (in_valid_i) begin
         if (in_sop_i) begin
            if (state_q == StIpCsum) short_d = 1'b1;
            state_d   = StEth;
            k_d       = 3'd0;
            t_d       = 3'd3;
            en_pkt_d  = enable_i;
            rewrite_d = 1'b0;
         end else begin
            case (state_q)
               StEth: begin
                  k_d = k_inc;
                  if (k_inc == t_q) begin
                     // A tag may only push the target forward, never back onto itself
                     if (in_data_i[15:0] == 16'h0800) state_d = StIpHdr0;
                     else if (in_data_i[15:0] == 16'h8100 && k_inc < 3'd4 && 3'd4 <= TMax)
                        t_d = 3'd4;
                     else if (in_data_i[15:0] == 16'h9100 && k_inc < 3'd5 && 3'd5 <= TMax)
                        t_d = 3'd5;
                     else state_d = StPass;
                  end
               end
               StIpHdr0: state_d = (in_data_i[31:28] == 4'h4) ? StIpId : StPass;
               StIpId: begin
                  if (en_pkt_q && msg_valid_i) begin
                     odata[31:16] = msg_data_i;
                     m_d          = in_data_i[31:16];
                     mn_d         = msg_data_i;
                     pop          = 1'b1;
                     rewrite_d    = 1'b1;
                     state_d      = StIpCsum;
                     if (in_eop_i) short_d = 1'b1;
                  end else begin
                     state_d = StPass;
                  end
               end
               StIpCsum: begin
                  if (rewrite_q) begin
                     odata[15:0] = hc_new;
                     cnt_d       = cnt_q + CNT_W'(1);
                  end
                  rewrite_d = 1'b0;
                  state_d   = StPass;
                  if (in_eop_i) short_d = 1'b1;
               end
               default: ;
            endcase
         end
         if (in_eop_i) begin
            state_d   = StIdle;
            rewrite_d = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q     <= StIdle;
         k_q         <= 3'd0;
         t_q         <= 3'd3;
         en_pkt_q    <= 1'b0;
         rewrite_q   <= 1'b0;
         m_q         <= 16'd0;
         mn_q        <= 16'd0;
         cnt_q       <= '0;
         short_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_data_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         t_q         <= t_d;
         en_pkt_q    <= en_pkt_d;
         rewrite_q   <= rewrite_d;
         m_q         <= m_d;
         mn_q        <= mn_d;
         cnt_q       <= cnt_d;
         short_q     <= short_d;
         out_valid_q <= in_valid_i;
         out_sop_q   <= in_sop_i;
         out_eop_q   <= in_eop_i;
         out_data_q  <= odata;
      end
   end

   // No pop while reset is held: the word would not be rewritten
   assign msg_pop_o     = pop & ~reset;
   assign out_valid_o   = out_valid_q;
   assign out_sop_o     = out_sop_q;
   assign out_eop_o     = out_eop_q;
   assign out_data_o    = out_data_q;
   assign embed_count_o = cnt_q;
   assign short_err_o   = short_q;

endmodule

// File: tb/tb_ip_id_embedder.sv
// Bench for ip_id_embedder: directed scenarios plus randomised packets checked against a
// packet-level model that recomputes the full IPv4 header checksum.
module tb_ip_id_embedder;

   logic        clk = 1'b0;
   logic        rst, iv, is, ie, en, mv;
   logic [31:0] id;
   logic [15:0] md;
   logic        pop, ov, os, oe, serr;
   logic [31:0] od, cnt;

   always #5 clk = ~clk;

   ip_id_embedder #(.CNT_W(32), .MAX_VLAN_TAGS(2)) dut (
      .sys_clk(clk), .reset(rst),
      .in_valid_i(iv), .in_sop_i(is), .in_eop_i(ie), .in_data_i(id),
      .enable_i(en), .msg_data_i(md), .msg_valid_i(mv), .msg_pop_o(pop),
      .out_valid_o(ov), .out_sop_o(os), .out_eop_o(oe), .out_data_o(od),
      .embed_count_o(cnt), .short_err_o(serr)
   );

   int          n_vec = 0, n_err = 0;
   logic [31:0] pkt[$], xw[$];
   int          pop_i, cs_i, exp_cnt;
   bit          emb, sh, exp_short;
   logic [15:0] last_cs;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full header checksum over five words, the checksum field itself excluded
   function automatic logic [15:0] ip_csum(input logic [31:0] w0, w1, w2, w3, w4);
      int unsigned s;
      s = 32'(w0[31:16]) + 32'(w0[15:0]) + 32'(w1[31:16]) + 32'(w1[15:0]) + 32'(w2[31:16])
        + 32'(w3[31:16]) + 32'(w3[15:0]) + 32'(w4[31:16]) + 32'(w4[15:0]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   task automatic model(input bit en_p, mv_p, input logic [15:0] md_p, input int rst_at);
      int n, lim, idx;
      logic [31:0] w;
      n = pkt.size(); xw = pkt; pop_i = -1; cs_i = -1; emb = 0; sh = 0;
      lim = (rst_at < 0) ? n : rst_at;
      idx = 3;
      if (pkt[3][15:0] == 16'h8100) idx = 4;
      else if (pkt[3][15:0] == 16'h9100) idx = 5;
      if (lim > idx + 2 && pkt[idx][15:0] == 16'h0800 && pkt[idx+1][31:28] == 4'h4
          && en_p && mv_p) begin
         w = xw[idx+2]; w[31:16] = md_p; xw[idx+2] = w; pop_i = idx + 2;
         if (idx + 2 == n - 1) sh = 1;
         else if (lim > idx + 3) begin
            w = xw[idx+3];
            w[15:0] = ip_csum(xw[idx+1], xw[idx+2], xw[idx+3], xw[idx+4], xw[idx+5]);
            xw[idx+3] = w; cs_i = idx + 3; emb = 1;
            if (idx + 3 == n - 1) sh = 1;
         end
      end
   endtask

   task automatic cyc(input logic v, s, e, input logic [31:0] d, input logic [31:0] xd,
                      input logic xpop, input logic r, input bit cs);
      rst = r; iv = v; is = s; ie = e; id = d;
      #1;
      chk("msg_pop", 64'(pop), 64'(xpop));
      @(posedge clk); #1;
      if (r) chk("out_after_reset", {ov, os, oe, od}, 64'd0);
      else   chk("out_word", {ov, os, oe, od}, {v, s, e, xd});
      if (cs) last_cs = od[15:0];
   endtask

   task automatic send(input bit en_p, mv_p, input logic [15:0] md_p, input int gap,
                       input int rst_at, input bit wiggle);
      int n;
      logic [31:0] j;
      model(en_p, mv_p, md_p, rst_at);
      n = pkt.size(); en = en_p; mv = mv_p; md = md_p; last_cs = 16'hxxxx;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, i == 0, i == n - 1, pkt[i], xw[i], i == pop_i, i == rst_at, i == cs_i);
         if (wiggle) en = 1'($urandom_range(0, 1));
         for (int g = 0; g < gap; g++) begin
            j = $urandom;
            cyc(1'b0, 1'b0, 1'b0, j, j, 1'b0, 1'b0, 1'b0);
         end
      end
      if (rst_at >= 0) begin
         exp_cnt = 0; exp_short = 0;
      end else begin
         exp_cnt += int'(emb); exp_short |= sh;
      end
      chk("embed_count", 64'(cnt), 64'(exp_cnt));
      chk("short_err", 64'(serr), 64'(exp_short));
   endtask

   // Reference header: ID 0x0000, checksum 0xB861
   task automatic fixed_pkt(input int ntag, input logic [15:0] et);
      pkt.delete();
      pkt.push_back(32'h0011_2233); pkt.push_back(32'h4455_6677); pkt.push_back(32'h8899_aabb);
      if (ntag == 0) pkt.push_back({16'hccdd, et});
      else if (ntag == 1) begin
         pkt.push_back(32'hccdd_8100); pkt.push_back({16'h0064, et});
      end else begin
         pkt.push_back(32'hccdd_9100); pkt.push_back(32'h00c8_8100); pkt.push_back({16'h0064, et});
      end
      pkt.push_back(32'h4500_0073); pkt.push_back(32'h0000_4000); pkt.push_back(32'h4011_b861);
      pkt.push_back(32'hc0a8_0001); pkt.push_back(32'hc0a8_00c7); pkt.push_back(32'hdead_beef);
   endtask

   task automatic rand_pkt(input int ntag, input bit ipok, input bit v4, input int npay);
      logic [15:0] et;
      logic [31:0] h0, h1, h2, h3, h4;
      et = ipok ? 16'h0800 : 16'h86DD;
      pkt.delete();
      for (int i = 0; i < 3; i++) pkt.push_back($urandom);
      if (ntag == 0) pkt.push_back({16'($urandom), et});
      else if (ntag == 1) begin
         pkt.push_back({16'($urandom), 16'h8100}); pkt.push_back({16'($urandom), et});
      end else begin
         pkt.push_back({16'($urandom), 16'h9100}); pkt.push_back($urandom);
         pkt.push_back({16'($urandom), et});
      end
      h0 = {v4 ? 4'h4 : 4'h6, 4'h5, 8'($urandom), 16'(20 + 4 * npay)};
      h1 = $urandom; h2 = {16'($urandom), 16'h0000}; h3 = $urandom; h4 = $urandom;
      h2[15:0] = ip_csum(h0, h1, h2, h3, h4);
      pkt.push_back(h0); pkt.push_back(h1); pkt.push_back(h2); pkt.push_back(h3);
      pkt.push_back(h4);
      for (int i = 0; i < npay; i++) pkt.push_back($urandom);
   endtask

   initial begin
      logic [15:0] rmd;
      bit ren, rmv;
      en = 1'b0; mv = 1'b0; md = 16'd0; exp_cnt = 0; exp_short = 0;
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("reset_count", 64'(cnt), 64'd0);
      chk("reset_short", 64'(serr), 64'd0);

      for (int t = 0; t < 3; t++) begin
         fixed_pkt(t, 16'h0800);
         send(1'b1, 1'b1, 16'h1234, 0, -1, 1'b0);
         chk("ref_csum", 64'(last_cs), 64'h0000_A62D);
      end
      fixed_pkt(0, 16'h86DD); send(1'b1, 1'b1, 16'h1234, 0, -1, 1'b0);
      fixed_pkt(0, 16'h0800); send(1'b0, 1'b1, 16'h1234, 0, -1, 1'b0);
      fixed_pkt(1, 16'h0800); send(1'b1, 1'b0, 16'h1234, 0, -1, 1'b0);
      fixed_pkt(0, 16'h0800); send(1'b1, 1'b1, 16'h1234, 3, -1, 1'b0);
      chk("gap_csum", 64'(last_cs), 64'h0000_A62D);

      // eop on the ID word, then a normal packet
      fixed_pkt(0, 16'h0800);
      while (pkt.size() > 6) void'(pkt.pop_back());
      send(1'b1, 1'b1, 16'h5a5a, 0, -1, 1'b0);
      fixed_pkt(2, 16'h0800); send(1'b1, 1'b1, 16'h1234, 1, -1, 1'b0);

      // reset on the ID word, then a full packet
      fixed_pkt(0, 16'h0800); send(1'b1, 1'b1, 16'h1234, 0, 5, 1'b0);
      fixed_pkt(0, 16'h0800); send(1'b1, 1'b1, 16'h1234, 0, -1, 1'b0);
      chk("post_reset_csum", 64'(last_cs), 64'h0000_A62D);

      for (int p = 0; p < 1000; p++) begin
         rand_pkt($urandom_range(0, 2), $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3));
         ren = $urandom_range(0, 4) != 0;
         rmv = $urandom_range(0, 4) != 0;
         // Avoid the +0/-0 representation ambiguity between incremental and full recompute
         for (int tries = 0; tries < 16; tries++) begin
            rmd = 16'($urandom);
            model(ren, rmv, rmd, -1);
            if (cs_i < 0 || (xw[cs_i][15:0] != 16'h0000 && xw[cs_i][15:0] != 16'hFFFF)) break;
         end
         send(ren, rmv, rmd, $urandom_range(0, 2), -1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
